// File: rtl/uart_rx_packet_fifo_pkg.sv
// rtl/uart_rx_packet_fifo_pkg.sv - shared constants and FIFO entry layout for the UART packet FIFO
// Ports: none (package)
package uart_rx_packet_fifo_pkg;

   localparam int DATA_W_DEFAULT     = 8;
   localparam int DEPTH_LOG2_DEFAULT = 4;

   // Each entry is {last, data}; the last tag sits just above the data byte.
   localparam int ENTRY_W  = DATA_W_DEFAULT + 1;
   localparam int LAST_BIT = DATA_W_DEFAULT;

   typedef struct packed {
      logic                      last;
      logic [DATA_W_DEFAULT-1:0] data;
   } entry_t;

   function automatic int entryWidth(input int dataW);
      return dataW + 1;
   endfunction

endpackage

// File: rtl/uart_rx_packet_fifo_if.sv
// rtl/uart_rx_packet_fifo_if.sv - receive-side and read-side signal bundle of the UART packet FIFO
// Ports (master drives / slave receives):
//   rx_data_ready, rx_data, rx_endofpacket : byte and end-of-packet pulses from the UART receiver
//   rd_en, clr_overflow                    : pop request and overflow clear from the consumer
//   rd_data, rd_last, empty, full, level,
//   pkt_count, overflow                    : FIFO head and status returned by the slave
interface uart_rx_packet_fifo_if #(
   parameter int DATA_W     = 8,
   parameter int DEPTH_LOG2 = 4
);
   logic              rx_data_ready;
   logic [DATA_W-1:0] rx_data;
   logic              rx_endofpacket;
   logic              rd_en;
   logic              clr_overflow;
   logic [DATA_W-1:0] rd_data;
   logic              rd_last;
   logic              empty;
   logic              full;
   logic [DEPTH_LOG2:0] level;
   logic [DEPTH_LOG2:0] pkt_count;
   logic              overflow;

   modport master (
      output rx_data_ready, rx_data, rx_endofpacket, rd_en, clr_overflow,
      input  rd_data, rd_last, empty, full, level, pkt_count, overflow
   );

   modport slave (
      input  rx_data_ready, rx_data, rx_endofpacket, rd_en, clr_overflow,
      output rd_data, rd_last, empty, full, level, pkt_count, overflow
   );
endinterface

// File: rtl/uart_rx_packet_fifo_sync_fifo.sv
// rtl/uart_rx_packet_fifo_sync_fifo.sv - first-word-fall-through synchronous FIFO with level count
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   push       : write request; pushOk reports whether it was taken
//   pushData   : entry to write
//   pop        : read request (ignored when empty)
//   headData   : current head entry, zero when empty
//   full, empty, level : occupancy status
module uart_rx_packet_fifo_sync_fifo #(
   parameter int WIDTH      = 9,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [WIDTH-1:0]      pushData,
   output logic                  pushOk,
   input  logic                  pop,
   output logic [WIDTH-1:0]      headData,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level
);
   localparam int                  Depth      = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DepthCount = (DEPTH_LOG2 + 1)'(Depth);

   logic [WIDTH-1:0]      mem [Depth];
   logic [DEPTH_LOG2-1:0] wrPtr;
   logic [DEPTH_LOG2-1:0] rdPtr;
   logic [DEPTH_LOG2:0]   count;
   logic                  doPop;

   assign full     = (count == DepthCount);
   assign empty    = (count == '0);
   assign level    = count;
   assign doPop    = pop && !empty;
   // When full, a same-cycle pop frees the slot the push lands in.
   assign pushOk   = push && (!full || doPop);
   assign headData = empty ? '0 : mem[rdPtr];

   always_ff @(posedge clk) begin
      if (pushOk) begin
         mem[wrPtr] <= pushData;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (pushOk) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (doPop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({pushOk, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/uart_rx_packet_fifo.sv
// rtl/uart_rx_packet_fifo.sv - packet-tagging FIFO behind the UART receiver
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : slave side of uart_rx_packet_fifo_if (receiver pulses in, FWFT head and status out)
module uart_rx_packet_fifo
   import uart_rx_packet_fifo_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEFAULT,
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   uart_rx_packet_fifo_if.slave bus
);
   localparam int EntryW  = entryWidth(DATA_W);
   localparam int LastBit = DATA_W;

   logic [DATA_W-1:0]   pendData;
   logic                pendValid;
   logic                commit;
   logic                commitLast;
   logic                pushOk;
   logic                pop;
   logic                popLast;
   logic [EntryW-1:0]   pushEntry;
   logic [EntryW-1:0]   headEntry;
   logic                full;
   logic                empty;
   logic [DEPTH_LOG2:0] level;
   logic [DEPTH_LOG2:0] pktCount;
   logic                overflow;

   // A byte is held back until the next event tells us whether it ends a packet.
   // EOP is handled before a simultaneous new byte, so the held byte gets last=1.
   always_comb begin
      commit     = pendValid && (bus.rx_data_ready || bus.rx_endofpacket);
      commitLast = pendValid && bus.rx_endofpacket;
      pushEntry  = {commitLast, pendData};
      pop        = bus.rd_en && !empty;
      popLast    = pop && headEntry[LastBit];
   end

   uart_rx_packet_fifo_sync_fifo #(
      .WIDTH      (EntryW),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (commit),
      .pushData (pushEntry),
      .pushOk   (pushOk),
      .pop      (bus.rd_en),
      .headData (headEntry),
      .full     (full),
      .empty    (empty),
      .level    (level)
   );

   // The pend update happens even when the commit of the previous byte is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         pendValid <= 1'b0;
         pendData  <= '0;
      end else if (bus.rx_data_ready) begin
         pendValid <= 1'b1;
         pendData  <= bus.rx_data;
      end else if (bus.rx_endofpacket) begin
         pendValid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pktCount <= '0;
      end else begin
         case ({pushOk && commitLast, popLast})
            2'b10:   pktCount <= pktCount + 1'b1;
            2'b01:   pktCount <= pktCount - 1'b1;
            default: pktCount <= pktCount;
         endcase
      end
   end

   // A drop in the same cycle as a clear leaves the flag set.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (commit && !pushOk) begin
         overflow <= 1'b1;
      end else if (bus.clr_overflow) begin
         overflow <= 1'b0;
      end
   end

   assign bus.rd_data   = headEntry[DATA_W-1:0];
   assign bus.rd_last   = headEntry[LastBit];
   assign bus.empty     = empty;
   assign bus.full      = full;
   assign bus.level     = level;
   assign bus.pkt_count = pktCount;
   assign bus.overflow  = overflow;
endmodule

// File: tb/tb_uart_rx_packet_fifo.sv
// tb/tb_uart_rx_packet_fifo.sv - self-checking bench for uart_rx_packet_fifo
module tb_uart_rx_packet_fifo;
   localparam int DATA_W     = 8;
   localparam int DEPTH_LOG2 = 4;
   localparam int DEPTH      = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   uart_rx_packet_fifo_if #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

   uart_rx_packet_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;

   // Scoreboard: expected committed entries {last, data}, oldest first.
   logic [8:0] sbq [$];
   logic       mPendV;
   logic [7:0] mPend;
   logic       mOvf;

   function automatic int modelPkts();
      int n = 0;
      foreach (sbq[i]) if (sbq[i][8]) n++;
      return n;
   endfunction

   // One clock: drive inputs, advance the model, then compare every output at edge+1.
   task automatic step(input logic rdy, input logic [7:0] d, input logic eop,
                       input logic rd, input logic clr, input logic rst);
      logic popNow, commit, lastTag, accept;
      logic [8:0] expHead;
      reset              = rst;
      bus.rx_data_ready  = rdy;
      bus.rx_data        = d;
      bus.rx_endofpacket = eop;
      bus.rd_en          = rd;
      bus.clr_overflow   = clr;
      if (rst) begin
         sbq.delete();
         mPendV = 1'b0;
         mOvf   = 1'b0;
      end else begin
         popNow  = rd && (sbq.size() > 0);
         commit  = mPendV && (rdy || eop);
         lastTag = mPendV && eop;
         accept  = commit && ((sbq.size() < DEPTH) || popNow);
         if (popNow) void'(sbq.pop_front());
         if (accept) sbq.push_back({lastTag, mPend});
         if (commit && !accept) mOvf = 1'b1;
         else if (clr) mOvf = 1'b0;
         if (rdy) begin
            mPend  = d;
            mPendV = 1'b1;
         end else if (eop) begin
            mPendV = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      reset              = 1'b0;
      bus.rx_data_ready  = 1'b0;
      bus.rx_data        = '0;
      bus.rx_endofpacket = 1'b0;
      bus.rd_en          = 1'b0;
      bus.clr_overflow   = 1'b0;
      expHead = (sbq.size() > 0) ? sbq[0] : 9'h000;
      tests++;
      if ({bus.rd_last, bus.rd_data} !== expHead) begin
         fails++;
         $display("FAIL head at %0t: got %h want %h", $time, {bus.rd_last, bus.rd_data}, expHead);
      end
      tests++;
      if (bus.level !== 5'(sbq.size())) begin
         fails++;
         $display("FAIL level at %0t: got %0d want %0d", $time, bus.level, sbq.size());
      end
      tests++;
      if (bus.empty !== (sbq.size() == 0) || bus.full !== (sbq.size() == DEPTH)) begin
         fails++;
         $display("FAIL empty/full at %0t: got %b/%b want level %0d", $time, bus.empty, bus.full, sbq.size());
      end
      tests++;
      if (bus.pkt_count !== 5'(modelPkts())) begin
         fails++;
         $display("FAIL pkt_count at %0t: got %0d want %0d", $time, bus.pkt_count, modelPkts());
      end
      tests++;
      if (bus.overflow !== mOvf) begin
         fails++;
         $display("FAIL overflow at %0t: got %b want %b", $time, bus.overflow, mOvf);
      end
   endtask

   task automatic test_reset();
      step(0, 8'h00, 0, 0, 0, 1);
      tests++;
      if ({bus.empty, bus.full, bus.level, bus.pkt_count, bus.overflow, bus.rd_data, bus.rd_last}
          !== {1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 8'h00, 1'b0}) begin
         fails++;
         $display("FAIL reset_state: got empty=%b full=%b level=%0d pkt=%0d ovf=%b data=%h last=%b want 1 0 0 0 0 00 0",
                  bus.empty, bus.full, bus.level, bus.pkt_count, bus.overflow, bus.rd_data, bus.rd_last);
      end
   endtask

   task automatic test_basic_packet();
      logic [7:0] want [3];
      want[0] = 8'h41; want[1] = 8'h42; want[2] = 8'h43;
      step(1, 8'h41, 0, 0, 0, 0);
      step(1, 8'h42, 0, 0, 0, 0);
      step(1, 8'h43, 0, 0, 0, 0);
      step(0, 8'h00, 1, 0, 0, 0);
      tests++;
      if (bus.level !== 5'd3 || bus.pkt_count !== 5'd1) begin
         fails++;
         $display("FAIL basic_counts: got level=%0d pkt=%0d want 3 1", bus.level, bus.pkt_count);
      end
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (bus.rd_data !== want[i] || bus.rd_last !== (i == 2)) begin
            fails++;
            $display("FAIL basic_read%0d: got %h/%b want %h/%b", i, bus.rd_data, bus.rd_last, want[i], (i == 2));
         end
         step(0, 8'h00, 0, 1, 0, 0);
      end
      tests++;
      if (bus.empty !== 1'b1 || bus.pkt_count !== 5'd0) begin
         fails++;
         $display("FAIL basic_drained: got empty=%b pkt=%0d want 1 0", bus.empty, bus.pkt_count);
      end
   endtask

   task automatic test_hold_back();
      step(0, 8'h00, 0, 0, 0, 1);
      step(1, 8'h55, 0, 0, 0, 0);
      tests++;
      if (bus.empty !== 1'b1 || bus.level !== 5'd0) begin
         fails++;
         $display("FAIL hold_single: got empty=%b level=%0d want 1 0", bus.empty, bus.level);
      end
      step(1, 8'h66, 0, 0, 0, 0);
      tests++;
      if (bus.level !== 5'd1 || bus.rd_data !== 8'h55 || bus.rd_last !== 1'b0) begin
         fails++;
         $display("FAIL hold_commit: got level=%0d head=%h/%b want 1 55/0", bus.level, bus.rd_data, bus.rd_last);
      end
      step(0, 8'h00, 1, 0, 0, 0);
      step(0, 8'h00, 0, 1, 0, 0);
      step(0, 8'h00, 0, 1, 0, 0);
   endtask

   task automatic test_overflow();
      step(0, 8'h00, 0, 0, 0, 1);
      for (int i = 0; i < 18; i++) step(1, 8'(8'h80 + i), 0, 0, 0, 0);
      step(0, 8'h00, 1, 0, 0, 0);
      tests++;
      if (bus.level !== 5'd16 || bus.full !== 1'b1 || bus.overflow !== 1'b1 || bus.pkt_count !== 5'd0) begin
         fails++;
         $display("FAIL overflow_state: got level=%0d full=%b ovf=%b pkt=%0d want 16 1 1 0",
                  bus.level, bus.full, bus.overflow, bus.pkt_count);
      end
      step(0, 8'h00, 0, 0, 1, 0);
      tests++;
      if (bus.overflow !== 1'b0) begin
         fails++;
         $display("FAIL overflow_clear: got %b want 0", bus.overflow);
      end
   endtask

   // Continues from the full FIFO left by test_overflow (0x80..0x8F, no pending byte).
   task automatic test_full_pushpop();
      step(1, 8'hA0, 0, 0, 0, 0);
      tests++;
      if (bus.rd_data !== 8'h80) begin
         fails++;
         $display("FAIL full_head: got %h want 80", bus.rd_data);
      end
      step(1, 8'hA1, 0, 1, 0, 0);
      tests++;
      if (bus.level !== 5'd16 || bus.overflow !== 1'b0 || bus.rd_data !== 8'h81) begin
         fails++;
         $display("FAIL full_pushpop: got level=%0d ovf=%b head=%h want 16 0 81", bus.level, bus.overflow, bus.rd_data);
      end
      for (int i = 0; i < 16; i++) begin
         if (i == 15) begin
            tests++;
            if (bus.rd_data !== 8'hA0 || bus.rd_last !== 1'b0) begin
               fails++;
               $display("FAIL full_tail: got %h/%b want a0/0", bus.rd_data, bus.rd_last);
            end
         end
         step(0, 8'h00, 0, 1, 0, 0);
      end
   endtask

   task automatic test_simultaneous();
      step(0, 8'h00, 0, 0, 0, 1);
      step(1, 8'h10, 0, 0, 0, 0);
      step(1, 8'h20, 1, 0, 0, 0);
      tests++;
      if (bus.pkt_count !== 5'd1 || bus.level !== 5'd1 || bus.rd_data !== 8'h10 || bus.rd_last !== 1'b1) begin
         fails++;
         $display("FAIL simul_eop: got pkt=%0d level=%0d head=%h/%b want 1 1 10/1",
                  bus.pkt_count, bus.level, bus.rd_data, bus.rd_last);
      end
      step(0, 8'h00, 1, 0, 0, 0);
      tests++;
      if (bus.pkt_count !== 5'd2 || bus.level !== 5'd2) begin
         fails++;
         $display("FAIL simul_second: got pkt=%0d level=%0d want 2 2", bus.pkt_count, bus.level);
      end
   endtask

   task automatic test_reset_mid();
      step(0, 8'h00, 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) step(1, 8'(8'h30 + i), 0, 0, 0, 0);
      tests++;
      if (bus.level !== 5'd5) begin
         fails++;
         $display("FAIL mid_level: got %0d want 5", bus.level);
      end
      step(0, 8'h00, 0, 0, 0, 1);
      tests++;
      if (bus.empty !== 1'b1 || bus.level !== 5'd0 || bus.pkt_count !== 5'd0 || bus.overflow !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset: got empty=%b level=%0d pkt=%0d ovf=%b want 1 0 0 0",
                  bus.empty, bus.level, bus.pkt_count, bus.overflow);
      end
      step(0, 8'h00, 1, 0, 0, 0);
      tests++;
      if (bus.empty !== 1'b1 || bus.level !== 5'd0) begin
         fails++;
         $display("FAIL mid_eop_after_reset: got empty=%b level=%0d want 1 0", bus.empty, bus.level);
      end
   endtask

   // Random traffic: a fill-biased phase then a drain-biased phase, exercising wrap and drops.
   task automatic test_back_to_back();
      step(0, 8'h00, 0, 0, 0, 1);
      for (int i = 0; i < 400; i++) begin
         logic rdy, eop, rd, clr;
         rdy = ($urandom_range(0, 3) != 0);
         eop = ($urandom_range(0, 4) == 0);
         rd  = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 15) == 0);
         step(rdy, 8'($urandom), eop, rd, clr, 0);
      end
   endtask

   initial begin
      reset              = 1'b1;
      bus.rx_data_ready  = 1'b0;
      bus.rx_data        = '0;
      bus.rx_endofpacket = 1'b0;
      bus.rd_en          = 1'b0;
      bus.clr_overflow   = 1'b0;
      mPendV             = 1'b0;
      mPend              = '0;
      mOvf               = 1'b0;
      test_reset();
      test_basic_packet();
      test_hold_back();
      test_overflow();
      test_full_pushpop();
      test_simultaneous();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
